// File: rtl/scheduler_pkg.sv
// Shared entry layout, FSM state encoding and round-robin helper for the accelerator selector.
package scheduler_pkg;

    localparam int ENTRY_W   = 50;
    localparam int TYPE_ID_W = 34;
    localparam int ACC_ID_W  = 8;
    localparam int CNT_W     = 4;

    typedef struct packed {
        logic [TYPE_ID_W-1:0] type_id;
        logic [ACC_ID_W-1:0]  first_acc;
        logic [CNT_W-1:0]     cnt_m1;
        logic [CNT_W-1:0]     last;
    } sched_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SELECT,
        ST_RESP,
        ST_WAIT
    } sched_state_t;

    // Offset following the last grant, wrapping after the final accelerator of the group.
    function automatic logic [CNT_W-1:0] rr_next(input logic [CNT_W-1:0] cnt_m1,
                                                 input logic [CNT_W-1:0] last);
        return (last >= cnt_m1) ? '0 : last + 4'd1;
    endfunction

endpackage

// File: rtl/scheduler_acc_select_scan.sv
// Rotating-priority scan: first offset from start (mod cnt_m1+1) whose accelerator is idle.
// Combinational; ids at or above MAX_ACCS count as busy. Result is consumed only with SCHED_BUSY_SKIP_EN.
module scheduler_acc_select_scan
    import scheduler_pkg::*;
#(
    parameter int MAX_ACCS = 16
) (
    input  logic [ACC_ID_W-1:0] first_acc,
    input  logic [CNT_W-1:0]    cnt_m1,
    input  logic [CNT_W-1:0]    start,
    input  logic [MAX_ACCS-1:0] acc_busy,
    output logic                found,
    output logic [CNT_W-1:0]    offset
);

    logic [255:0]          busy_ext;
    logic [CNT_W:0]        cand;
    logic [ACC_ID_W-1:0]   id;

    always_comb begin
        busy_ext                 = '1;
        busy_ext[MAX_ACCS-1:0]   = acc_busy;
        found                    = 1'b0;
        offset                   = start;
        cand                     = '0;
        id                       = '0;
        for (int i = 0; i < 16; i++) begin
            // start <= cnt_m1 and i <= cnt_m1, so one subtraction completes the modulo.
            cand = {1'b0, start} + 5'(i);
            if (cand > {1'b0, cnt_m1})
                cand = cand - ({1'b0, cnt_m1} + 5'd1);
            id = first_acc + {4'b0, cand[CNT_W-1:0]};
            if (!found && (4'(i) <= cnt_m1) && !busy_ext[id]) begin
                found  = 1'b1;
                offset = cand[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/scheduler_acc_select.sv
// Per-type round-robin accelerator selector over an external scheduling-info memory; one request in flight.
// Accept-to-rsp_valid 3 cycles; response held until rsp_ready; SCHED_BUSY_SKIP_EN enables busy-skip with WAIT.
module scheduler_acc_select
    import scheduler_pkg::*;
#(
    parameter int MAX_ACC_TYPES = 16,
    parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
    parameter int MAX_ACCS      = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ACC_TYPE_BITS-1:0] req_acc_type,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ACC_ID_W-1:0]      rsp_acc_id,
    output logic [TYPE_ID_W-1:0]     rsp_type_id,
    output logic [ACC_TYPE_BITS-1:0] sched_info_rd_addr,
    output logic                     sched_info_rd_en,
    input  logic [ENTRY_W-1:0]       sched_info_rd_dout,
    output logic [ACC_TYPE_BITS-1:0] sched_info_wr_addr,
    output logic                     sched_info_wr_en,
    output logic [ENTRY_W-1:0]       sched_info_wr_din,
    input  logic [MAX_ACCS-1:0]      acc_busy
);

    sched_state_t              state_q, state_d;
    logic [ACC_TYPE_BITS-1:0]  type_q;
    sched_entry_t              entry_q;
    sched_entry_t              rd_entry;
    logic [CNT_W-1:0]          next_q;
    logic [ACC_ID_W-1:0]       acc_id_q;

    logic [ACC_ID_W-1:0]       sel_first;
    logic [CNT_W-1:0]          sel_cnt;
    logic [CNT_W-1:0]          sel_last;
    logic [CNT_W-1:0]          rr;
    logic                      pick_ok;
    logic [CNT_W-1:0]          pick;
    logic                      scan_found;
    logic [CNT_W-1:0]          scan_offset;

    assign rd_entry = sched_entry_t'(sched_info_rd_dout);

    // SELECT sees the fresh read data; WAIT re-scans from the registered copy.
    assign sel_first = (state_q == ST_SELECT) ? rd_entry.first_acc : entry_q.first_acc;
    assign sel_cnt   = (state_q == ST_SELECT) ? rd_entry.cnt_m1    : entry_q.cnt_m1;
    assign sel_last  = (state_q == ST_SELECT) ? rd_entry.last      : entry_q.last;
    assign rr        = rr_next(sel_cnt, sel_last);

    scheduler_acc_select_scan #(
        .MAX_ACCS (MAX_ACCS)
    ) u_scan (
        .first_acc (sel_first),
        .cnt_m1    (sel_cnt),
        .start     (rr),
        .acc_busy  (acc_busy),
        .found     (scan_found),
        .offset    (scan_offset)
    );

`ifdef SCHED_BUSY_SKIP_EN
    assign pick_ok = scan_found;
    assign pick    = scan_offset;
`else
    logic unused_scan;
    assign unused_scan = ^{scan_found, scan_offset};
    assign pick_ok     = 1'b1;
    assign pick        = rr;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_READ;
            ST_READ:   state_d = ST_SELECT;
            ST_SELECT: state_d = pick_ok ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (pick_ok) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            type_q   <= '0;
            entry_q  <= '0;
            next_q   <= '0;
            acc_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid)
                type_q <= req_acc_type;
            if (state_q == ST_SELECT)
                entry_q <= rd_entry;
            if ((state_q == ST_SELECT || state_q == ST_WAIT) && pick_ok) begin
                next_q   <= pick;
                acc_id_q <= sel_first + {4'b0, pick};
            end
        end
    end

    assign req_ready          = (state_q == ST_IDLE);
    assign sched_info_rd_en   = (state_q == ST_READ);
    assign sched_info_rd_addr = type_q;
    assign rsp_valid          = (state_q == ST_RESP);
    assign rsp_acc_id         = acc_id_q;
    assign rsp_type_id        = entry_q.type_id;
    // Write-back lands on the handshake edge, so a following request reads the updated entry.
    assign sched_info_wr_en   = (state_q == ST_RESP) && rsp_ready;
    assign sched_info_wr_addr = type_q;
    assign sched_info_wr_din  = {entry_q.type_id, entry_q.first_acc, entry_q.cnt_m1, next_q};

endmodule
